regfile_wb_arbiter: RTL and testbench

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_wb_arbiter.sv | 111 +++++++++++
 tb/tb_regfile_wb_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Arbitrates two writeback requesters (m0 = ALU, m1 = load) onto the single
//   register-file write port, and runs a sweep that writes zero to registers
//   1..31 on request or after reset.
//
// Ports
//   clk, resetn            clock, synchronous active-low reset
//   clr_req                start a clear sweep (ignored while one is running)
//   m0_valid/addr/data     requester 0 write request, m0_ready accept (comb)
//   m1_valid/addr/data     requester 1 write request, m1_ready accept (comb)
//   we3, a3, wd3           registered register-file write port
//   busy                   clear sweep in progress (comb, state == CLEAR)
//   grant_id               index of the last accepted requester (registered)
module regfile_wb_arbiter #(
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        clr_req,
  input  logic        m0_valid,
  input  logic [4:0]  m0_addr,
  input  logic [31:0] m0_data,
  output logic        m0_ready,
  input  logic        m1_valid,
  input  logic [4:0]  m1_addr,
  input  logic [31:0] m1_data,
  output logic        m1_ready,
  output logic        we3,
  output logic [4:0]  a3,
  output logic [31:0] wd3,
  output logic        busy,
  output logic        grant_id
);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t      state, state_nxt;
  logic [4:0]  cnt, cnt_nxt;
  logic        we_nxt;
  logic [4:0]  a_nxt;
  logic [31:0] d_nxt;
  logic        gid_nxt;
  logic        pick1;

  assign busy = (state == CLEAR);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    we_nxt    = 1'b0;
    a_nxt     = a3;
    d_nxt     = wd3;
    gid_nxt   = grant_id;
    m0_ready  = 1'b0;
    m1_ready  = 1'b0;
    pick1     = 1'b0;
    case (state)
      IDLE: begin
        if (clr_req) begin
          state_nxt = CLEAR;
          cnt_nxt   = 5'd1;
        end else begin
          // On a tie the requester that did not win last time goes next.
          if (m0_valid && m1_valid) pick1 = ~grant_id;
          else                      pick1 = m1_valid;
          m0_ready = m0_valid && !pick1;
          m1_ready = m1_valid && pick1;
          if (m0_ready || m1_ready) begin
            gid_nxt = pick1;
            a_nxt   = pick1 ? m1_addr : m0_addr;
            d_nxt   = pick1 ? m1_data : m0_data;
            // r0 is hardwired zero: accept the transfer but drop the write.
            we_nxt  = ((pick1 ? m1_addr : m0_addr) != 5'd0);
          end
        end
      end
      CLEAR: begin
        we_nxt = 1'b1;
        a_nxt  = cnt;
        d_nxt  = 32'd0;
        // Counter parks at 1 when the sweep ends so it never wraps to 0.
        if (cnt == 5'd31) begin
          state_nxt = IDLE;
          cnt_nxt   = 5'd1;
        end else begin
          cnt_nxt = cnt + 5'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= CLEAR_ON_RESET ? CLEAR : IDLE;
      cnt      <= 5'd1;
      we3      <= 1'b0;
      a3       <= 5'd0;
      wd3      <= 32'd0;
      grant_id <= 1'b1;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      we3      <= we_nxt;
      a3       <= a_nxt;
      wd3      <= d_nxt;
      grant_id <= gid_nxt;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        resetn, clr_req;
  logic        m0_valid, m1_valid;
  logic [4:0]  m0_addr, m1_addr;
  logic [31:0] m0_data, m1_data;
  logic        m0_ready, m1_ready;
  logic        we3, busy, grant_id;
  logic [4:0]  a3;
  logic [31:0] wd3;

  int tests = 0;
  int fails = 0;

  regfile_wb_arbiter #(.CLEAR_ON_RESET(1'b1)) dut (
    .clk(clk), .resetn(resetn), .clr_req(clr_req),
    .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_data(m0_data), .m0_ready(m0_ready),
    .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_data(m1_data), .m1_ready(m1_ready),
    .we3(we3), .a3(a3), .wd3(wd3), .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: the sweep is a queue of addresses still to be zeroed;
  // the port is busy while that queue is non-empty.
  int          sq[$];
  logic        e_we, e_gid;
  logic [4:0]  e_a;
  logic [31:0] e_d;
  bit          mvalid = 0;

  // bit0 = m0 accepted, bit1 = m1 accepted
  function automatic logic [1:0] exp_ready();
    if (!mvalid || sq.size() != 0 || clr_req) return 2'b00;
    if (m0_valid && m1_valid) return e_gid ? 2'b01 : 2'b10;
    return {m1_valid, m0_valid};
  endfunction

  task automatic load_sweep();
    sq.delete();
    for (int i = 1; i < 32; i++) sq.push_back(i);
  endtask

  always @(posedge clk) begin
    logic [1:0] r;
    r = exp_ready();
    if (!resetn) begin
      load_sweep();
      e_we = 0; e_a = 0; e_d = 0; e_gid = 1; mvalid = 1;
    end else if (sq.size() != 0) begin
      e_a  = 5'(sq.pop_front());
      e_we = 1;
      e_d  = 0;
    end else if (clr_req) begin
      load_sweep();
      e_we = 0;
    end else if (r != 2'b00) begin
      e_a   = r[1] ? m1_addr : m0_addr;
      e_d   = r[1] ? m1_data : m0_data;
      e_gid = r[1];
      e_we  = (e_a != 5'd0);
    end else begin
      e_we = 0;
    end
  end

  always @(negedge clk) begin
    logic [1:0] r;
    #3;
    if (mvalid) begin
      r = exp_ready();
      chk("we3", 32'(we3), 32'(e_we));
      chk("a3", 32'(a3), 32'(e_a));
      chk("wd3", wd3, e_d);
      chk("grant_id", 32'(grant_id), 32'(e_gid));
      chk("busy", 32'(busy), 32'(sq.size() != 0));
      chk("m0_ready", 32'(m0_ready), 32'(r[0]));
      chk("m1_ready", 32'(m1_ready), 32'(r[1]));
    end
  end

  initial begin
    bit found;
    resetn = 0; clr_req = 0;
    m0_valid = 0; m0_addr = 0; m0_data = 0;
    m1_valid = 0; m1_addr = 0; m1_data = 0;
    repeat (3) @(negedge clk);

    // Reset release: 31-write sweep a3 = 1..31
    resetn = 1;
    #4;
    chk("lit_busy_after_reset", 32'(busy), 32'd1);
    chk("lit_m0_ready_in_reset_sweep", 32'(m0_ready), 32'd0);
    chk("lit_grant_after_reset", 32'(grant_id), 32'd1);
    for (int i = 1; i <= 31; i++) begin
      @(negedge clk); #4;
      chk("lit_sweep_we3", 32'(we3), 32'd1);
      chk("lit_sweep_a3", 32'(a3), 32'(i));
      chk("lit_sweep_wd3", wd3, 32'd0);
    end
    @(negedge clk); #4;
    chk("lit_post_sweep_busy", 32'(busy), 32'd0);
    chk("lit_post_sweep_we3", 32'(we3), 32'd0);

    // Single m0 write
    @(negedge clk);
    m0_valid = 1; m0_addr = 5'd5; m0_data = 32'hDEADBEEF;
    #4;
    chk("lit_m0_ready", 32'(m0_ready), 32'd1);
    @(negedge clk);
    m0_valid = 0;
    #4;
    chk("lit_m0_we3", 32'(we3), 32'd1);
    chk("lit_m0_a3", 32'(a3), 32'd5);
    chk("lit_m0_wd3", wd3, 32'hDEADBEEF);
    chk("lit_m0_gid", 32'(grant_id), 32'd0);
    @(negedge clk); #4;
    chk("lit_idle_we3", 32'(we3), 32'd0);
    chk("lit_idle_a3_hold", 32'(a3), 32'd5);

    // Back to reset state, then both requesters contend for 4 cycles
    @(negedge clk); resetn = 0;
    @(negedge clk); resetn = 1;
    repeat (31) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      m0_valid = 1; m0_addr = 5'd3; m0_data = 32'h33;
      m1_valid = 1; m1_addr = 5'd4; m1_data = 32'h44;
      #4;
      chk("lit_rr_m0_ready", 32'(m0_ready), 32'((k % 2) == 0));
      chk("lit_rr_m1_ready", 32'(m1_ready), 32'((k % 2) == 1));
      if (k > 0) begin
        chk("lit_rr_we3", 32'(we3), 32'd1);
        chk("lit_rr_a3", 32'(a3), (k % 2) == 1 ? 32'd3 : 32'd4);
      end
    end
    @(negedge clk);
    m0_valid = 0; m1_valid = 0;
    #4;
    chk("lit_rr_last_a3", 32'(a3), 32'd4);
    chk("lit_rr_last_wd3", wd3, 32'h44);

    // m1 write to r0 is accepted but dropped; grant still moves to m1
    @(negedge clk);
    m0_valid = 1; m0_addr = 5'd9; m0_data = 32'h99;
    #4;
    chk("lit_m0_again_ready", 32'(m0_ready), 32'd1);
    @(negedge clk);
    m0_valid = 0;
    m1_valid = 1; m1_addr = 5'd0; m1_data = 32'h1234;
    #4;
    chk("lit_r0_m1_ready", 32'(m1_ready), 32'd1);
    @(negedge clk);
    m1_valid = 0;
    #4;
    chk("lit_r0_we3", 32'(we3), 32'd0);
    chk("lit_r0_gid", 32'(grant_id), 32'd1);

    // clr_req beats a pending m0 request; a mid-sweep clr_req is ignored
    @(negedge clk);
    clr_req = 1; m0_valid = 1; m0_addr = 5'd7; m0_data = 32'h77;
    #4;
    chk("lit_clr_m0_ready", 32'(m0_ready), 32'd0);
    @(negedge clk);
    clr_req = 0;
    #4;
    chk("lit_clr_busy", 32'(busy), 32'd1);
    for (int j = 1; j <= 30; j++) begin
      @(negedge clk);
      clr_req = (j == 10);
      #4;
      chk("lit_clr_sweep_busy", 32'(busy), 32'd1);
      chk("lit_clr_sweep_stall", 32'(m0_ready), 32'd0);
    end
    @(negedge clk);
    clr_req = 0;
    #4;
    chk("lit_clr_done_busy", 32'(busy), 32'd0);
    chk("lit_clr_done_a3", 32'(a3), 32'd31);
    chk("lit_clr_m0_served", 32'(m0_ready), 32'd1);
    @(negedge clk);
    m0_valid = 0;
    #4;
    chk("lit_clr_m0_a3", 32'(a3), 32'd7);
    chk("lit_clr_m0_wd3", wd3, 32'h77);
    chk("lit_clr_m0_we3", 32'(we3), 32'd1);

    // Reset in the middle of a sweep aborts it; sweep restarts at 1
    @(negedge clk); clr_req = 1;
    @(negedge clk); clr_req = 0;
    found = 0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk); #4;
      if (a3 == 5'd10 && busy) found = 1;
    end
    if (!found) begin
      tests++; fails++;
      $display("FAIL wait_a3_10: got timeout expected a3=10 within 40 cycles");
    end
    resetn = 0;
    @(negedge clk);
    resetn = 1;
    #4;
    chk("lit_abort_we3", 32'(we3), 32'd0);
    chk("lit_abort_a3", 32'(a3), 32'd0);
    @(negedge clk); #4;
    chk("lit_restart_we3", 32'(we3), 32'd1);
    chk("lit_restart_a3", 32'(a3), 32'd1);
    repeat (32) @(negedge clk);
    #5;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
